// File: rtl/imem_loader.sv
// imem_loader: turns a host byte stream into 32-bit instruction memory
// writes and holds the CPU in reset until a complete image has arrived.
//
// Ports:
//   clk, rst_n         clock, async active-low reset
//   start              one-cycle pulse, begins a load when not busy
//   in_valid, in_data  host byte stream
//   in_ready           loader takes a byte this cycle
//   wr_en              one-cycle strobe per assembled word
//   wr_addr, wr_data   byte address and big-endian word
//   busy, done, err    load status; done/err held until the next start
//   cpu_hold           processor reset request, released on a clean load
//
// Optional: define IMEM_LOADER_CHECKSUM_EN to expect a trailing XOR
// checksum byte covering the header and all data bytes.
module imem_loader #(
   parameter int unsigned DEPTH     = 32,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   output logic        wr_en,
   output logic [31:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic        cpu_hold
);

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      BYTES,
      WRITE,
      FIN,
      CHK
   } state_t;

   state_t     state;
   logic [1:0] byte_cnt;
   logic [7:0] word_cnt;
   logic [7:0] n_words;
   logic [7:0] csum;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         in_ready <= 1'b0;
         wr_en    <= 1'b0;
         wr_addr  <= BASE_ADDR;
         wr_data  <= 32'd0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
         cpu_hold <= 1'b1;
         byte_cnt <= 2'd0;
         word_cnt <= 8'd0;
         n_words  <= 8'd0;
         csum     <= 8'd0;
      end else begin
         wr_en <= 1'b0;
         unique case (state)
            IDLE, FIN: begin
               if (start) begin
                  state    <= HDR;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
                  done     <= 1'b0;
                  err      <= 1'b0;
                  cpu_hold <= 1'b1;
                  wr_addr  <= BASE_ADDR;
                  byte_cnt <= 2'd0;
                  word_cnt <= 8'd0;
                  csum     <= 8'd0;
               end
            end
            HDR: begin
               if (in_valid) begin
                  n_words <= in_data;
                  csum    <= in_data;
                  if (in_data == 8'd0) begin
                     state    <= FIN;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else if (32'(in_data) > DEPTH) begin
                     state    <= FIN;
                     in_ready <= 1'b0;
                     busy     <= 1'b0;
                     err      <= 1'b1;
                  end else begin
                     state <= BYTES;
                  end
               end
            end
            BYTES: begin
               if (in_valid) begin
                  // shift in MSB first: first byte ends up in [31:24]
                  wr_data  <= {wr_data[23:0], in_data};
                  csum     <= csum ^ in_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     state    <= WRITE;
                     in_ready <= 1'b0;
                     wr_en    <= 1'b1;
                  end
               end
            end
            WRITE: begin
               wr_addr  <= wr_addr + 32'd4;
               word_cnt <= word_cnt + 8'd1;
               if (word_cnt + 8'd1 == n_words) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                  state    <= CHK;
                  in_ready <= 1'b1;
`else
                  state    <= FIN;
                  busy     <= 1'b0;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
`endif
               end else begin
                  state    <= BYTES;
                  in_ready <= 1'b1;
               end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            CHK: begin
               if (in_valid) begin
                  state    <= FIN;
                  in_ready <= 1'b0;
                  busy     <= 1'b0;
                  if (in_data == csum) begin
                     done     <= 1'b1;
                     cpu_hold <= 1'b0;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
`endif
            default: begin
               state    <= IDLE;
               in_ready <= 1'b0;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: randomized and directed loads of imem_loader,
// checked against a stream-level model of the expected writes.
module tb_imem_loader;

   localparam int unsigned DEPTH = 32;
   localparam logic [31:0] BASE  = 32'h0000_0000;

   typedef logic [7:0] bq_t[$];

   logic        clk = 0;
   logic        rst_n = 0;
   logic        start = 0;
   logic        in_valid = 0;
   logic [7:0]  in_data = 0;
   logic        in_ready;
   logic        wr_en;
   logic [31:0] wr_addr;
   logic [31:0] wr_data;
   logic        busy;
   logic        done;
   logic        err;
   logic        cpu_hold;

   int errors = 0;
   int checks = 0;
   int viol = 0;
   logic [31:0] wa[$];
   logic [31:0] wd[$];

   imem_loader #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .busy(busy), .done(done), .err(err), .cpu_hold(cpu_hold)
   );

   always #5 clk = ~clk;

   // capture writes; while busy, in_ready must be low exactly in write cycles
   always @(negedge clk) begin
      if (wr_en) begin
         wa.push_back(wr_addr);
         wd.push_back(wr_data);
      end
      if (busy && (in_ready == wr_en)) viol++;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_reset();
      check("rst_rdy", in_ready, 0);
      check("rst_wen", wr_en, 0);
      check("rst_addr", wr_addr, BASE);
      check("rst_data", wr_data, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_hold", cpu_hold, 1);
   endtask

   task automatic pulse_start();
      start = 1;
      @(posedge clk); #1;
      start = 0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      int n;
      bit ok;
      if (gap > 0) begin
         repeat (gap) @(posedge clk);
         #1;
      end
      in_valid = 1;
      in_data = b;
      n = 0;
      ok = 0;
      while (!ok && n < 50) begin
         @(negedge clk);
         if (in_ready) ok = 1;
         n++;
      end
      if (!ok) check("hs_tmo", 0, 1);
      @(posedge clk); #1;
      in_valid = 0;
      in_data = 8'($urandom);
   endtask

   // build a stream: header, 4n random bytes, plus checksum when enabled
   function automatic bq_t mk(input int n, input bit bad);
      bq_t q;
      logic [7:0] x;
      q.push_back(8'(n));
      if (n == 0 || n > int'(DEPTH)) return q;
      for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
`ifdef IMEM_LOADER_CHECKSUM_EN
      x = 0;
      foreach (q[i]) x ^= q[i];
      q.push_back(bad ? (x ^ 8'h5A) : x);
`else
      x = 8'(bad);
      if (x == 8'hFF) q.delete();
`endif
      return q;
   endfunction

   task automatic do_load(input bq_t s, input int lo, input int hi,
                          input int start_at);
      int n;
      int nw;
      int k;
      bit e_err;
      bit e_done;
      logic [7:0] x;
      wa.delete();
      wd.delete();
      pulse_start();
      viol = 0;
      check("st_busy", busy, 1);
      check("st_done", done, 0);
      check("st_err", err, 0);
      check("st_hold", cpu_hold, 1);
      check("st_addr", wr_addr, BASE);
      foreach (s[i]) begin
         if (i == start_at) pulse_start();
         send_byte(s[i], $urandom_range(hi, lo));
      end
      k = 0;
      while (busy && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("fin_busy", busy, 0);
      n = s[0];
      e_err = n > int'(DEPTH);
      e_done = !e_err;
      nw = e_err ? 0 : n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      if (nw > 0) begin
         x = 0;
         for (int i = 0; i <= 4 * nw; i++) x ^= s[i];
         if (s[4 * nw + 1] != x) begin
            e_err = 1;
            e_done = 0;
         end
      end
`endif
      check("nwr", wa.size(), nw);
      for (int i = 0; i < nw && i < wa.size(); i++) begin
         check("waddr", wa[i], BASE + 32'(4 * i));
         check("wdata", wd[i], {s[1 + 4 * i], s[2 + 4 * i],
                                s[3 + 4 * i], s[4 + 4 * i]});
      end
      check("done", done, e_done);
      check("err", err, e_err);
      check("hold", cpu_hold, !(e_done && !e_err));
      check("fin_rdy", in_ready, 0);
      check("rdy_rule", viol, 0);
   endtask

   initial begin
      bq_t s;
      repeat (3) @(posedge clk);
      #1;
      check_reset();
      rst_n = 1;
      @(posedge clk); #1;
      check_reset();

      s = '{8'h02, 8'h24, 8'h04, 8'h00, 8'h00, 8'h8C, 8'h90, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h02 ^ 8'h24 ^ 8'h04 ^ 8'h8C ^ 8'h90);
`endif
      do_load(s, 0, 0, -1);
      check("a0", wa.size() > 0 ? wa[0] : 32'hx, 32'h0);
      check("d0", wd.size() > 0 ? wd[0] : 32'hx, 32'h2404_0000);
      check("d1", wd.size() > 1 ? wd[1] : 32'hx, 32'h8C90_0000);
      do_load(s, 3, 3, -1);
      do_load(s, 0, 2, 3);

      s = '{8'h00};
      do_load(s, 0, 0, -1);
      s = '{8'd33};
      do_load(s, 0, 1, -1);

      // reset in the middle of a word
      pulse_start();
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 0);
      rst_n = 0;
      #3;
      check_reset();
      @(posedge clk); #1;
      rst_n = 1;
      @(posedge clk); #1;
      s = '{8'h01, 8'hAC, 8'h89, 8'h00, 8'h18};
`ifdef IMEM_LOADER_CHECKSUM_EN
      s.push_back(8'h3C);
`endif
      do_load(s, 0, 1, -1);
      check("rl_d0", wd.size() > 0 ? wd[0] : 32'hx, 32'hAC89_0018);
`ifdef IMEM_LOADER_CHECKSUM_EN
      s[5] = 8'h00;
      do_load(s, 0, 1, -1);
      check("ck_bad", err, 1);
`endif

      for (int r = 0; r < 10; r++) begin
         int n;
         n = ($urandom_range(4, 0) == 0) ? $urandom_range(255, 33)
                                         : $urandom_range(6, 1);
         if (r == 9) n = DEPTH;
         do_load(mk(n, $urandom_range(3, 0) == 0), 0, 3,
                 $urandom_range(20, 2));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout got=1 exp=0");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the processor's instruction memory: receives a byte stream from a host link and assembles it into 32-bit instruction words.
- Issues one-cycle write strobes to a writable instruction memory, using byte addresses in steps of 4 so that word = addr >> 2.
- Holds the CPU in reset until a full image has been loaded.

Parameters:
- DEPTH, 32, number of 32-bit words in instruction memory; maximum image length.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; begins a load when idle or done.
- in_valid  input  1  host byte valid.
- in_data  input  8  host byte.
- in_ready  output  1  loader accepts a byte this cycle; a transfer occurs when in_valid && in_ready.
- wr_en  output  1  instruction memory write strobe, one cycle per word.
- wr_addr  output  32  byte address of the word, BASE_ADDR + 4*k.
- wr_data  output  32  assembled instruction word.
- busy  output  1  load in progress.
- done  output  1  load finished; held until the next start.
- err  output  1  load aborted on a bad header (or checksum, see option); held until the next start.
- cpu_hold  output  1  keeps the processor in reset while high.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - in_ready=0, wr_en=0, wr_addr=BASE_ADDR, wr_data=0.
  - busy=0, done=0, err=0, cpu_hold=1.
  - Byte counter, word counter and partial word cleared.
  - Reset mid-load discards the partial word; words already written are not rewritten.
- States: IDLE, HDR, BYTES, WRITE, FIN.
- IDLE:
  - in_ready=0.
  - start -> HDR; clear done/err; cpu_hold=1; busy=1; wr_addr=BASE_ADDR.
- HDR:
  - in_ready=1; the first accepted byte is the word count N (unsigned).
  - N=0 -> FIN, no writes, done=1.
  - N>DEPTH -> FIN, err=1, no writes.
  - Otherwise -> BYTES.
- BYTES:
  - in_ready=1; bytes are big-endian (first byte -> wr_data[31:24]).
  - On the 4th accepted byte of a word -> WRITE.
- WRITE:
  - Lasts exactly one cycle; in_ready=0.
  - wr_en=1 with wr_addr/wr_data stable for that cycle.
  - Next cycle wr_addr += 4.
  - If the word count reaches N -> FIN with done=1; else -> BYTES.
- FIN:
  - busy=0, in_ready=0.
  - cpu_hold=0 only if done=1 and err=0; on err, cpu_hold stays 1.
  - start -> HDR, as from IDLE.
- General rules:
  - start while busy is ignored.
  - Bytes offered while in_ready=0 are not consumed.
  - in_valid gaps of any length are tolerated; the byte position is preserved.
  - Latency: wr_en asserts the cycle after the 4th byte handshake.
  - Minimum load time is 1 + 5N cycles of accepted traffic.
  - wr_addr is 32-bit modular; no wrap is possible since N<=DEPTH.

Optional Feature:
- Macro IMEM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last word, the loader waits in an extra state CHK with in_ready=1 for one byte.
  - The expected byte is the XOR of N and all 4N data bytes.
  - Match -> FIN with done=1.
  - Mismatch -> FIN with err=1, done=0, cpu_hold=1.
  - Words already written remain in memory.
- Undefined: no CHK state; FIN follows the last WRITE directly; err is set only by a bad header.

Test Plan:
- Load N=2, bytes 24 04 00 00 8C 90 00 00 -> wr_en pulses at (0x0, 0x24040000) and (0x4, 0x8C900000); then done=1, cpu_hold=0, busy=0.
- Same stream with in_valid low for 3 cycles between every byte -> identical writes; in_ready=0 only in the WRITE cycles.
- Header N=0 -> no wr_en; done=1, err=0, cpu_hold=0. Header N=33 with DEPTH=32 -> no wr_en; err=1, cpu_hold=1.
- rst_n pulled low after 2 data bytes, then released and a fresh load of N=1 (AC 89 00 18) -> single write (0x0, 0xAC890018); the earlier partial bytes never appear.
- start pulsed during BYTES -> ignored. Second start after done -> done/err cleared, cpu_hold=1, reload begins at BASE_ADDR.
- With IMEM_LOADER_CHECKSUM_EN: N=1, AC 89 00 18, checksum 0x3C -> done=1. Checksum 0x00 -> err=1, cpu_hold=1.
